axi_slave_read_responder: RTL and testbench

AXI_SLAVE_READ_RESPONDER -- requirements
Module: axi_slave_read_responder

---
 rtl/axi_slave_read_responder.sv | 177 +++++++++++++++++
 tb/tb_axi_slave_read_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_read_responder.sv
// ============================================================================
// Module   : axi_slave_read_responder
// Purpose  : AXI3-style read-only slave in front of a single-port 32-bit SRAM
//            with one-cycle read latency. Serves one burst at a time, and each
//            beat takes three cycles (MEM -> CAP -> RESP).
// Ports    : ACLK, ARESETn        - clock, asynchronous active-low reset
//            AR*_S                - read-address channel (slave side)
//            R*_S                 - read-data channel (slave side)
//            mem_cs/mem_addr      - SRAM read strobe and word address
//            mem_rdata            - SRAM data, valid the cycle after mem_cs
// Options  : RD_RANGE_CHECK_EN    - when defined, a burst whose upper address
//                                   bits [31:MEM_AW+2] are nonzero returns
//                                   SLVERR with zero data and never strobes
//                                   the SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module axi_slave_read_responder #(
  parameter int MEM_AW = 14
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  // read-address channel
  input  logic [`AXI_IDS_BITS-1:0] ARID_S,
  input  logic [31:0]              ARADDR_S,
  input  logic [3:0]               ARLEN_S,
  input  logic [2:0]               ARSIZE_S,
  input  logic [1:0]               ARBURST_S,
  input  logic                     ARVALID_S,
  output logic                     ARREADY_S,
  // read-data channel
  output logic [`AXI_IDS_BITS-1:0] RID_S,
  output logic [31:0]              RDATA_S,
  output logic [1:0]               RRESP_S,
  output logic                     RLAST_S,
  output logic                     RVALID_S,
  input  logic                     RREADY_S,
  // SRAM port
  output logic                     mem_cs,
  output logic [MEM_AW-1:0]        mem_addr,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_CAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0]        c_RESP_OKAY   = 2'b00;
  localparam logic [1:0]        c_RESP_SLVERR = 2'b10;
  localparam logic [MEM_AW-1:0] c_ADDR_ONE    = {{(MEM_AW-1){1'b0}}, 1'b1};

  state_t                   r_state;
  logic [`AXI_IDS_BITS-1:0] r_id;
  logic [3:0]               r_len;
  logic [3:0]               r_beat;
  logic                     r_fixed;
  logic [MEM_AW-1:0]        r_addr;
  logic [31:0]              r_rdata_q;
  logic [1:0]               r_rresp;
  logic                     r_arready;
  logic                     r_rvalid;
  logic                     r_rlast;
  logic                     r_mem_cs;

  // w_ar_ok : incoming AR targets the attached SRAM
  // w_oor   : the burst in flight is out of range (latched at AR time)
  logic w_ar_ok;
  logic w_oor;
  logic w_unused_bits;

`ifdef RD_RANGE_CHECK_EN
  logic r_oor;
  assign w_ar_ok       = ~(|ARADDR_S[31:MEM_AW+2]);
  assign w_oor         = r_oor;
  assign w_unused_bits = ^{ARSIZE_S, ARADDR_S[1:0]};
`else
  assign w_ar_ok       = 1'b1;
  assign w_oor         = 1'b0;
  assign w_unused_bits = ^{ARSIZE_S, ARADDR_S[1:0], ARADDR_S[31:MEM_AW+2]};
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_id      <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_fixed   <= 1'b0;
      r_addr    <= '0;
      r_rdata_q <= '0;
      r_rresp   <= c_RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_mem_cs  <= 1'b0;
`ifdef RD_RANGE_CHECK_EN
      r_oor     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // ARREADY comes up on the first edge out of reset and stays up
          // until an address is accepted.
          r_arready <= 1'b1;
          if (ARVALID_S && r_arready) begin
            r_id      <= ARID_S;
            r_addr    <= ARADDR_S[MEM_AW+1:2];
            r_len     <= ARLEN_S;
            r_fixed   <= (ARBURST_S == 2'b00);
            r_beat    <= 4'd0;
            r_arready <= 1'b0;
            r_mem_cs  <= w_ar_ok;
`ifdef RD_RANGE_CHECK_EN
            r_oor     <= ~w_ar_ok;
`endif
            r_state   <= S_MEM;
          end
        end

        S_MEM: begin
          r_mem_cs <= 1'b0;
          r_state  <= S_CAP;
        end

        S_CAP: begin
          // mem_rdata belongs to the strobe issued in MEM.
          r_rdata_q <= w_oor ? 32'd0 : mem_rdata;
          r_rresp   <= w_oor ? c_RESP_SLVERR : c_RESP_OKAY;
          r_rvalid  <= 1'b1;
          r_rlast   <= (r_beat == r_len);
          r_state   <= S_RESP;
        end

        S_RESP: begin
          if (RREADY_S) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_beat <= r_beat + 4'd1;
              // INCR and WRAP both step by one word; the SRAM space is
              // treated as circular, so the address simply rolls over.
              if (!r_fixed)
                r_addr <= r_addr + c_ADDR_ONE;
              r_mem_cs <= ~w_oor;
              r_state  <= S_MEM;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ARREADY_S = r_arready;
  assign RID_S     = r_id;
  assign RDATA_S   = r_rdata_q;
  assign RRESP_S   = r_rresp;
  assign RLAST_S   = r_rlast;
  assign RVALID_S  = r_rvalid;
  assign mem_cs    = r_mem_cs;
  assign mem_addr  = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_read_responder.sv
// ============================================================================
// Module   : tb_axi_slave_read_responder
// Purpose  : Self-checking bench for axi_slave_read_responder. Directed bursts
//            followed by randomized bursts, each checked against a burst-level
//            reference model (beat addresses, data, RLAST, latency, strobes).
//            Honors RD_RANGE_CHECK_EN in its expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_slave_read_responder;

  localparam int AW = 14;

  logic          ACLK;
  logic          ARESETn;
  logic [7:0]    ARID_S;
  logic [31:0]   ARADDR_S;
  logic [3:0]    ARLEN_S;
  logic [2:0]    ARSIZE_S;
  logic [1:0]    ARBURST_S;
  logic          ARVALID_S;
  logic          ARREADY_S;
  logic [7:0]    RID_S;
  logic [31:0]   RDATA_S;
  logic [1:0]    RRESP_S;
  logic          RLAST_S;
  logic          RVALID_S;
  logic          RREADY_S;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cs_count = 0;

  axi_slave_read_responder #(.MEM_AW(AW)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARID_S    (ARID_S),
    .ARADDR_S  (ARADDR_S),
    .ARLEN_S   (ARLEN_S),
    .ARSIZE_S  (ARSIZE_S),
    .ARBURST_S (ARBURST_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Synthetic SRAM contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {18'd0, a};
    return 32'hC0DE_0000 ^ (w * 32'h0001_0193) ^ {a, 18'd0};
  endfunction

  // One-cycle-latency SRAM; garbage when not strobed so a mistimed capture shows.
  always @(posedge ACLK) begin
    mem_rdata <= mem_cs ? memf(mem_addr) : $urandom;
    if (mem_cs === 1'b1) cs_count <= cs_count + 1;
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // After a reset pulse: ARREADY must stay low until the first edge after release.
  task automatic reset_release;
    tick;
    ARESETn = 1'b1;
    chk("arready_before_edge", 32'(ARREADY_S), 32'd0);
    tick;
    chk("arready_after_release", 32'(ARREADY_S), 32'd1);
  endtask

  // Runs one burst and checks every beat against the model.
  // stall_beat/stall_cycles: hold RREADY low that many cycles on that beat.
  // abort_beat: assert reset while that beat is being presented (-1 = none).
  task automatic do_burst(input logic [7:0] id, input logic [31:0] araddr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input int stall_beat, input int stall_cycles,
                          input int abort_beat);
    logic [AW-1:0] a0;
    logic [AW-1:0] a;
    logic [31:0]   exp_data;
    logic [1:0]    exp_resp;
    logic          oor;
    int            c0;
    int            w;
    a0 = araddr[AW+1:2];
`ifdef RD_RANGE_CHECK_EN
    oor = (araddr[31:AW+2] != '0);
`else
    oor = 1'b0;
`endif
    c0 = cs_count;
    ARID_S    = id;
    ARADDR_S  = araddr;
    ARLEN_S   = len;
    ARBURST_S = burst;
    ARSIZE_S  = 3'($urandom);
    ARVALID_S = 1'b1;
    w = 0;
    while (ARREADY_S !== 1'b1 && w < 20) begin
      tick;
      w++;
    end
    chk("arready_wait", 32'(ARREADY_S), 32'd1);
    tick;
    // Scramble AR inputs: the burst must run from latched values only.
    ARVALID_S = 1'b0;
    ARID_S    = 8'($urandom);
    ARADDR_S  = $urandom;
    ARLEN_S   = 4'($urandom);
    ARBURST_S = 2'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      a        = (burst == 2'b00) ? a0 : a0 + AW'(i);
      exp_data = oor ? 32'd0 : memf(a);
      exp_resp = oor ? 2'b10 : 2'b00;
      // MEM cycle
      chk("mem_cs_pulse", 32'(mem_cs), 32'(!oor));
      chk("mem_addr", 32'(mem_addr), 32'(a));
      chk("arready_busy", 32'(ARREADY_S), 32'd0);
      chk("rvalid_in_mem", 32'(RVALID_S), 32'd0);
      tick;
      // CAP cycle
      chk("mem_cs_in_cap", 32'(mem_cs), 32'd0);
      chk("rvalid_in_cap", 32'(RVALID_S), 32'd0);
      tick;
      // RESP cycle
      chk("rvalid", 32'(RVALID_S), 32'd1);
      chk("rdata", RDATA_S, exp_data);
      chk("rid", 32'(RID_S), 32'(id));
      chk("rresp", 32'(RRESP_S), 32'(exp_resp));
      chk("rlast", 32'(RLAST_S), 32'(i == int'(len)));
      chk("mem_cs_in_resp", 32'(mem_cs), 32'd0);
      if (i == abort_beat) begin
        ARESETn = 1'b0;
        #1;
        chk("abort_rvalid", 32'(RVALID_S), 32'd0);
        chk("abort_mem_cs", 32'(mem_cs), 32'd0);
        chk("abort_rlast", 32'(RLAST_S), 32'd0);
        chk("abort_arready", 32'(ARREADY_S), 32'd0);
        chk("abort_rdata", RDATA_S, 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        return;
      end
      if (i == stall_beat) begin
        RREADY_S = 1'b0;
        repeat (stall_cycles) begin
          tick;
          chk("hold_rvalid", 32'(RVALID_S), 32'd1);
          chk("hold_rdata", RDATA_S, exp_data);
          chk("hold_rid", 32'(RID_S), 32'(id));
          chk("hold_rresp", 32'(RRESP_S), 32'(exp_resp));
          chk("hold_rlast", 32'(RLAST_S), 32'(i == int'(len)));
          chk("hold_mem_cs", 32'(mem_cs), 32'd0);
        end
      end
      RREADY_S = 1'b1;
      tick;
      RREADY_S = 1'b0;
    end
    chk("arready_after_last", 32'(ARREADY_S), 32'd1);
    chk("rvalid_idle", 32'(RVALID_S), 32'd0);
    chk("rlast_idle", 32'(RLAST_S), 32'd0);
    chk("mem_cs_idle", 32'(mem_cs), 32'd0);
    chk("mem_cs_count", 32'(cs_count - c0), oor ? 32'd0 : 32'(int'(len) + 1));
  endtask

  initial begin
    logic [31:0] ra;
    ARESETn   = 1'b1;
    ARID_S    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b0;
    #1 ARESETn = 1'b0;
    tick;
    tick;
    // Reset state
    chk("rst_arready", 32'(ARREADY_S), 32'd0);
    chk("rst_rvalid", 32'(RVALID_S), 32'd0);
    chk("rst_rlast", 32'(RLAST_S), 32'd0);
    chk("rst_rid", 32'(RID_S), 32'd0);
    chk("rst_rdata", RDATA_S, 32'd0);
    chk("rst_rresp", 32'(RRESP_S), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset_release;

    // Single read
    do_burst(8'h15, 32'h0000_0010, 4'd0, 2'b01, -1, 0, -1);
    // INCR burst of 4
    do_burst(8'h21, 32'h0000_0000, 4'd3, 2'b01, -1, 0, -1);
    // FIXED burst with 5 cycles of backpressure on the first beat
    do_burst(8'h3C, 32'h0000_0200, 4'd2, 2'b00, 0, 5, -1);
    // Address roll-over at the top of the SRAM
    do_burst(8'h07, 32'h0000_FFFC, 4'd1, 2'b01, -1, 0, -1);
    // WRAP steps like INCR
    do_burst(8'h42, 32'h0000_0FF8, 4'd2, 2'b10, 1, 2, -1);
    // Maximum length burst
    do_burst(8'hE1, 32'h0000_1230, 4'd15, 2'b01, 15, 3, -1);
    // Reset during beat 2 of an 8-beat burst, then a fresh burst
    do_burst(8'h5A, 32'h0000_0100, 4'd7, 2'b01, -1, 0, 1);
    reset_release;
    do_burst(8'h66, 32'h0000_0040, 4'd1, 2'b01, -1, 0, -1);
    // Upper address bits set (SLVERR when range checking is built in)
    do_burst(8'h11, 32'h0001_0000, 4'd1, 2'b01, -1, 0, -1);

    // Randomized bursts
    for (int k = 0; k < 25; k++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[31:AW+2] = '0;
      do_burst(8'($urandom), ra, 4'($urandom), 2'($urandom),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
